// File: rtl/expr_gen.sv
// LFSR-driven generator of ASCII expressions of the form digit (op digit)*,
// emitted one character per valid/ready transfer.
module expr_gen #(
    parameter int          LW       = 4,
    parameter logic [15:0] DEF_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic [15:0]   seed,
    output logic [7:0]    out_char,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG  = 2'd1,
        OP   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t        state_reg;
    logic [15:0]   lfsr_reg;
    logic [15:0]   lfsr_next;
    logic [LW-1:0] rem_reg;
    logic [3:0]    nib;
    logic [3:0]    digit;
    logic          accept;

    // Fibonacci step: taps 16,14,13,11 feed bit 0, everything else shifts up.
    assign lfsr_next[0] = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    genvar gi;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    assign nib       = lfsr_reg[3:0];
    assign digit     = (nib >= 4'd10) ? (nib - 4'd10) : nib;
    assign out_valid = (state_reg == DIG) || (state_reg == OP);
    assign accept    = out_valid & out_ready;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FIN);

    // Characters are decoded from held state, so they stay stable under backpressure.
    always_comb begin
        out_char = 8'h00;
        out_last = 1'b0;
        case (state_reg)
            DIG: begin
                out_char = 8'h30 + {4'h0, digit};
                out_last = (rem_reg == LW'(1));
            end
            OP: begin
                out_char = lfsr_reg[4] ? 8'h2A : 8'h2B;
            end
            default: begin
                out_char = 8'h00;
                out_last = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg <= IDLE;
            lfsr_reg  <= DEF_SEED;
            rem_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        lfsr_reg  <= (seed == 16'h0000) ? DEF_SEED : seed;
                        rem_reg   <= len;
                        state_reg <= (len == '0) ? FIN : DIG;
                    end
                end
                DIG: begin
                    if (accept) begin
                        lfsr_reg  <= lfsr_next;
                        rem_reg   <= rem_reg - LW'(1);
                        state_reg <= (rem_reg == LW'(1)) ? FIN : OP;
                    end
                end
                OP: begin
                    if (accept) begin
                        lfsr_reg  <= lfsr_next;
                        state_reg <= DIG;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
